// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared branch types, condition codes and NZCV bit indices
package branch_pkg;

  typedef enum logic [2:0] {
    BT_NONE  = 3'd0,
    BT_B     = 3'd1,
    BT_BCOND = 3'd2,
    BT_CBZ   = 3'd3,
    BT_CBNZ  = 3'd4,
    BT_BR    = 3'd5
  } branch_type_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational ARM condition-code evaluator over an NZCV nibble
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = nzcv_i[NZCV_N];
  assign z = nzcv_i[NZCV_Z];
  assign c = nzcv_i[NZCV_C];
  assign v = nzcv_i[NZCV_V];

  always_comb begin
    pass_o = 1'b1;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c & !z;
      COND_LS: pass_o = !(c & !z);
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z & (n == v);
      COND_LE: pass_o = !(!z & (n == v));
      default: pass_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - NZCV flag register and branch resolution with registered redirect
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [2:0]        br_type,
  input  logic [3:0]        cond,
  input  logic [25:0]       br_imm,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] reg_val,
  input  logic              reg_zero,
  input  logic              flag_wr,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic              out_taken,
  output logic [ADDR_W-1:0] out_target,
  output logic [3:0]        flags
);

  logic [3:0]        flags_q, flags_d;
  logic              out_valid_q, out_valid_d;
  logic              out_taken_q, out_taken_d;
  logic [ADDR_W-1:0] out_target_q, out_target_d;

  branch_type_t      bt;
  logic              cap;
  logic [3:0]        alu_nzcv;
  logic [3:0]        eff_nzcv;
  logic              cond_pass;
  logic              taken;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] off_imm26;
  logic [ADDR_W-1:0] off_imm19;

  assign bt       = branch_type_t'(br_type);
  assign cap      = in_valid & !stall & !flush;
  assign alu_nzcv = {alu_neg, alu_zero, alu_carry, alu_ovf};

  // An ADDS merged with its B.cond must see the flags it is about to write.
  assign eff_nzcv = (flag_wr && bt == BT_BCOND) ? alu_nzcv : flags_q;

  cond_eval u_cond_eval (
    .cond_i (cond),
    .nzcv_i (eff_nzcv),
    .pass_o (cond_pass)
  );

  assign off_imm26 = {{(ADDR_W-28){br_imm[25]}}, br_imm, 2'b00};
  assign off_imm19 = {{(ADDR_W-21){br_imm[18]}}, br_imm[18:0], 2'b00};

  always_comb begin
    taken  = 1'b0;
    target = '0;
    case (bt)
      BT_B: begin
        taken  = 1'b1;
        target = pc + off_imm26;
      end
      BT_BCOND: begin
        taken  = cond_pass;
        target = pc + off_imm19;
      end
      BT_CBZ: begin
        taken  = reg_zero;
        target = pc + off_imm19;
      end
      BT_CBNZ: begin
        taken  = !reg_zero;
        target = pc + off_imm19;
      end
      BT_BR: begin
        taken  = 1'b1;
        target = reg_val[ADDR_W-1:0];
      end
      default: begin
        taken  = 1'b0;
        target = '0;
      end
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (cap && flag_wr) begin
      flags_d = alu_nzcv;
    end
  end

  // Flush beats stall; a flush keeps the old target so only valid/taken drop.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_taken_d  = out_taken_q;
    out_target_d = out_target_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_taken_d = 1'b0;
    end else if (!stall) begin
      out_valid_d = in_valid;
      out_taken_d = in_valid & taken;
      if (in_valid) begin
        out_target_d = target;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q      <= 4'b0000;
      out_valid_q  <= 1'b0;
      out_taken_q  <= 1'b0;
      out_target_q <= '0;
    end else begin
      flags_q      <= flags_d;
      out_valid_q  <= out_valid_d;
      out_taken_q  <= out_taken_d;
      out_target_q <= out_target_d;
    end
  end

  assign flags      = flags_q;
  assign out_valid  = out_valid_q;
  assign out_taken  = out_taken_q;
  assign out_target = out_target_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Downstream consumer of the 64-bit zero-detect logic. Takes the ALU zero result (for flag-setting ops) and the register-operand zero result (for CBZ/CBNZ).
- Holds the architectural NZCV flag register and evaluates B, B.cond, CBZ, CBNZ and BR.
- Produces a registered, one-cycle-latency redirect (taken + target) to the fetch stage. The front end predicts not-taken, so any taken branch is a redirect.

Parameters:
- ADDR_W, 64, PC/target width.
- DATA_W, 64, register operand width (BR target source).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  a branch or flag-setting op is present this cycle
- br_type  input  3  branch_type_t: NONE, B, BCOND, CBZ, CBNZ, BR
- cond  input  4  ARM condition code for BCOND
- br_imm  input  26  raw immediate: imm26 for B; low 19 bits used for BCOND/CBZ/CBNZ
- pc  input  ADDR_W  PC of the instruction
- reg_val  input  DATA_W  Rn value (BR target)
- reg_zero  input  1  zero-detect of the CBZ/CBNZ operand
- flag_wr  input  1  instruction sets flags (ADDS/SUBS)
- alu_zero  input  1  zero-detect of the ALU result
- alu_neg  input  1  ALU result bit 63
- alu_carry  input  1  ALU carry-out
- alu_ovf  input  1  ALU signed overflow
- stall  input  1  freeze this stage
- flush  input  1  squash the instruction in this stage
- out_valid  output  1  registered result valid
- out_taken  output  1  branch resolved taken (redirect fetch)
- out_target  output  ADDR_W  redirect address
- flags  output  4  current NZCV, {N,Z,C,V}

Behaviour:
- Reset (asynchronous, takes effect immediately): flags=4'b0000, out_valid=0, out_taken=0, out_target=0.
- Capture condition: cap = in_valid & !stall & !flush.
- Flag register:
  - On a clk edge with cap & flag_wr: flags <= {alu_neg, alu_zero, alu_carry, alu_ovf}.
  - Otherwise flags hold, including when stall or flush is high.
- Flag bypass: if flag_wr and br_type==BCOND are both high in the same cycle, the condition is evaluated on the incoming ALU flags, not the stored flags. This covers ADDS immediately followed by B.cond when both are merged into this stage.
- Condition evaluation (eff = stored or bypassed flags):
  - EQ 0000: Z. NE 0001: !Z.
  - CS 0010: C. CC 0011: !C.
  - MI 0100: N. PL 0101: !N.
  - VS 0110: V. VC 0111: !V.
  - HI 1000: C&!Z. LS 1001: !(C&!Z).
  - GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: !Z&(N==V). LE 1101: !(!Z&(N==V)).
  - 1110 and 1111: always true.
- Taken per br_type:
  - B and BR: always taken.
  - BCOND: condition result.
  - CBZ: reg_zero.
  - CBNZ: !reg_zero.
  - NONE: never taken.
- Target:
  - B: pc + (sext(br_imm[25:0]) << 2).
  - BCOND, CBZ, CBNZ: pc + (sext(br_imm[18:0]) << 2).
  - BR: reg_val[ADDR_W-1:0].
  - NONE: 0.
  - Addition is modulo 2^ADDR_W; wrap-around is silent.
- Output register, one-cycle latency. On a clk edge, priority order is:
  1. flush: out_valid<=0, out_taken<=0, out_target unchanged.
  2. stall: all outputs hold.
  3. otherwise: out_valid<=in_valid; out_taken<=in_valid & taken; out_target<=computed target. Target is loaded only when in_valid=1, else held.
- in_valid=0 and no stall/flush: out_valid<=0, out_taken<=0.
- flush and stall both high: flush wins.
- reset mid-stall or mid-flush: the reset values above apply immediately.
- out_taken is never 1 when out_valid is 0.

Decomposition:
- Package branch_pkg:
  - branch_type_t enum (3 bits: NONE=0, B=1, BCOND=2, CBZ=3, CBNZ=4, BR=5).
  - cond_t 4-bit constants COND_EQ … COND_AL.
  - NZCV bit-index constants.
- Sub-module cond_eval: combinational (cond, nzcv) -> pass. It is instantiated once and verified standalone.

Test Plan:
- Reset: assert reset mid-cycle with out_valid=1 -> outputs and flags go to 0 immediately, without waiting for clk.
- ADDS then B.EQ:
  - Cycle 1: in_valid=1, flag_wr=1, alu_zero=1, others 0 -> flags=4'b0100.
  - Cycle 2: BCOND, cond=0000, pc=0x1000, imm19=0x00004 -> next cycle out_taken=1, out_target=0x1010.
- Bypass: same-cycle flag_wr=1 with alu_neg=1, alu_ovf=0, plus BCOND cond=1011 (LT) and stored flags 0000 -> out_taken=1.
- CBNZ backward branch: reg_zero=0, pc=0x2000, imm19=0x7FFFF (-1) -> out_taken=1, out_target=0x1FFC.
- CBZ not-taken: reg_zero=0 -> out_valid=1, out_taken=0.
- Wrap-around: B with pc=0xFFFF_FFFF_FFFF_FFFC, imm26=1 -> out_target=0x0.
- BR: reg_val=0xDEAD_BEE0 -> out_taken=1, out_target=0xDEAD_BEE0.
- Stall/flush: with out_valid=1, out_taken=1:
  - stall=1 for 3 cycles with new inputs applied -> outputs unchanged and flags unchanged.
  - flush=1 together with stall=1 -> out_valid=0 and out_taken=0 next edge, flags unchanged.
